// File: rtl/multi_range_finder.sv
// multi_range_finder: streaming min/max/range tracker for NCH tagged channels.
// A go..finish window collects per-channel statistics; after finish one
// registered result word per channel is reported in channel order.
// Optional build macro RANGE_SIGNED_EN: samples are two's complement and all
// compares are signed (default build: unsigned samples).
module multi_range_finder #(
    parameter int WIDTH = 16,
    parameter int NCH   = 4,
    parameter int CW    = $clog2(NCH)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             go,
    input  logic             finish,
    input  logic             data_valid,
    input  logic [WIDTH-1:0] data_in,
    input  logic [CW-1:0]    data_chan,
    output logic             busy,
    output logic             result_valid,
    output logic [CW-1:0]    result_chan,
    output logic [WIDTH-1:0] result_min,
    output logic [WIDTH-1:0] result_max,
    output logic [WIDTH-1:0] result_range,
    output logic             result_empty,
    output logic             debug_error
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_REPORT = 2'd2
    } state_t;

    // Window start values: the first sample of a channel always replaces them.
`ifdef RANGE_SIGNED_EN
    localparam logic [WIDTH-1:0] INIT_MIN = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] INIT_MAX = {1'b1, {(WIDTH-1){1'b0}}};
`else
    localparam logic [WIDTH-1:0] INIT_MIN = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] INIT_MAX = {WIDTH{1'b0}};
`endif

    // One extra bit so a tag can be compared against NCH without wrapping.
    localparam logic [CW:0]   NCH_W   = (CW+1)'(NCH);
    localparam logic [CW-1:0] LAST_CH = CW'(NCH - 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    rpt_q, rpt_d;
    logic [WIDTH-1:0] min_q  [NCH];
    logic [WIDTH-1:0] min_d  [NCH];
    logic [WIDTH-1:0] max_q  [NCH];
    logic [WIDTH-1:0] max_d  [NCH];
    logic             seen_q [NCH];
    logic             seen_d [NCH];
    logic             err_q, err_d;
    logic             rvalid_q, rvalid_d;
    logic [CW-1:0]    rchan_q, rchan_d;
    logic [WIDTH-1:0] rmin_q, rmin_d;
    logic [WIDTH-1:0] rmax_q, rmax_d;
    logic [WIDTH-1:0] rrange_q, rrange_d;
    logic             rempty_q, rempty_d;

    logic             go_acc;
    logic             fin_acc;
    logic             chan_ok;
    logic             err_set;
    logic             load;
    logic [CW-1:0]    sel;

    function automatic logic is_lt(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
`ifdef RANGE_SIGNED_EN
        return $signed(a) < $signed(b);
`else
        return a < b;
`endif
    endfunction

    function automatic logic is_gt(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
`ifdef RANGE_SIGNED_EN
        return $signed(a) > $signed(b);
`else
        return a > b;
`endif
    endfunction

    assign busy         = (state_q != S_IDLE);
    assign result_valid = rvalid_q;
    assign result_chan  = rchan_q;
    assign result_min   = rmin_q;
    assign result_max   = rmax_q;
    assign result_range = rrange_q;
    assign result_empty = rempty_q;
    assign debug_error  = err_q;

    // Next-state: window control, per-channel statistics, result word and error flag.
    always_comb begin
        state_d  = state_q;
        rpt_d    = rpt_q;
        min_d    = min_q;
        max_d    = max_q;
        seen_d   = seen_q;
        rvalid_d = 1'b0;
        rchan_d  = rchan_q;
        rmin_d   = rmin_q;
        rmax_d   = rmax_q;
        rrange_d = rrange_q;
        rempty_d = rempty_q;
        load     = 1'b0;
        sel      = '0;

        go_acc  = (state_q == S_IDLE) && go && !finish;
        fin_acc = (state_q == S_RUN) && finish && !go;
        chan_ok = ({1'b0, data_chan} < NCH_W);
        err_set = (go && finish)
                || (finish && (state_q == S_IDLE))
                || (go && (state_q != S_IDLE))
                || (data_valid && (state_q != S_RUN))
                || (data_valid && (state_q == S_RUN) && !chan_ok);

        case (state_q)
            S_IDLE: begin
                if (go_acc) begin
                    for (int c = 0; c < NCH; c++) begin
                        min_d[c]  = INIT_MIN;
                        max_d[c]  = INIT_MAX;
                        seen_d[c] = 1'b0;
                    end
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (data_valid && chan_ok) begin
                    for (int c = 0; c < NCH; c++) begin
                        if (data_chan == c[CW-1:0]) begin
                            if (is_lt(data_in, min_q[c])) min_d[c] = data_in;
                            if (is_gt(data_in, max_q[c])) max_d[c] = data_in;
                            seen_d[c] = 1'b1;
                        end
                    end
                end
                // Channel 0 is loaded from the updated stats so a sample in
                // the finish cycle is part of its result.
                if (fin_acc) begin
                    state_d = S_REPORT;
                    rpt_d   = '0;
                    load    = 1'b1;
                    sel     = '0;
                end
            end
            S_REPORT: begin
                if (rpt_q == LAST_CH) begin
                    state_d = S_IDLE;
                end else begin
                    rpt_d = rpt_q + 1'b1;
                    load  = 1'b1;
                    sel   = rpt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (load) begin
            rvalid_d = 1'b1;
            rchan_d  = sel;
            for (int c = 0; c < NCH; c++) begin
                if (sel == c[CW-1:0]) begin
                    if (seen_d[c]) begin
                        rmin_d   = min_d[c];
                        rmax_d   = max_d[c];
                        rrange_d = max_d[c] - min_d[c];
                        rempty_d = 1'b0;
                    end else begin
                        rmin_d   = '0;
                        rmax_d   = '0;
                        rrange_d = '0;
                        rempty_d = 1'b1;
                    end
                end
            end
        end

        // A protocol violation wins over the clear from an accepted go.
        if (err_set)     err_d = 1'b1;
        else if (go_acc) err_d = 1'b0;
        else             err_d = err_q;
    end

    // State, statistics and registered result outputs; reset aborts everything.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            rpt_q    <= '0;
            for (int c = 0; c < NCH; c++) begin
                min_q[c]  <= '1;
                max_q[c]  <= '0;
                seen_q[c] <= 1'b0;
            end
            err_q    <= 1'b0;
            rvalid_q <= 1'b0;
            rchan_q  <= '0;
            rmin_q   <= '0;
            rmax_q   <= '0;
            rrange_q <= '0;
            rempty_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rpt_q    <= rpt_d;
            min_q    <= min_d;
            max_q    <= max_d;
            seen_q   <= seen_d;
            err_q    <= err_d;
            rvalid_q <= rvalid_d;
            rchan_q  <= rchan_d;
            rmin_q   <= rmin_d;
            rmax_q   <= rmax_d;
            rrange_q <= rrange_d;
            rempty_q <= rempty_d;
        end
    end

endmodule

// File: tb/tb_multi_range_finder.sv
// Testbench for multi_range_finder (WIDTH=16, NCH=4 main instance plus an
// NCH=5 instance for out-of-range channel tags). Build with or without
// RANGE_SIGNED_EN; expectations follow the selected mode.
module tb_multi_range_finder;

    logic        clock;
    logic        reset_n;
    logic        go, finish, data_valid;
    logic [15:0] data_in;
    logic [1:0]  data_chan;
    logic        busy, result_valid, result_empty, debug_error;
    logic [1:0]  result_chan;
    logic [15:0] result_min, result_max, result_range;

    logic        go_5, finish_5, data_valid_5;
    logic [15:0] data_in_5;
    logic [2:0]  data_chan_5;
    logic        busy_5, result_valid_5, result_empty_5, debug_error_5;
    logic [2:0]  result_chan_5;
    logic [15:0] result_min_5, result_max_5, result_range_5;

    int n_checks;
    int n_fail;

    typedef struct packed {
        logic [2:0]       ns;
        logic             fin_last;
        logic [3:0][1:0]  ch;
        logic [3:0][15:0] val;
        logic [3:0]       eempty;
        logic [3:0][15:0] emin;
        logic [3:0][15:0] emax;
    } vec_t;

    typedef struct packed {
        logic [1:0]  chan;
        logic [15:0] mn;
        logic [15:0] mx;
        logic [15:0] rg;
        logic        empty;
    } exp_t;

    vec_t vecs [4];
    exp_t sbq [$];

    multi_range_finder #(.WIDTH(16), .NCH(4)) dut (
        .clock(clock), .reset_n(reset_n), .go(go), .finish(finish),
        .data_valid(data_valid), .data_in(data_in), .data_chan(data_chan),
        .busy(busy), .result_valid(result_valid), .result_chan(result_chan),
        .result_min(result_min), .result_max(result_max),
        .result_range(result_range), .result_empty(result_empty),
        .debug_error(debug_error)
    );

    multi_range_finder #(.WIDTH(16), .NCH(5)) dut5 (
        .clock(clock), .reset_n(reset_n), .go(go_5), .finish(finish_5),
        .data_valid(data_valid_5), .data_in(data_in_5), .data_chan(data_chan_5),
        .busy(busy_5), .result_valid(result_valid_5), .result_chan(result_chan_5),
        .result_min(result_min_5), .result_max(result_max_5),
        .result_range(result_range_5), .result_empty(result_empty_5),
        .debug_error(debug_error_5)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic add_smp(input int v, input int i, input logic [1:0] c, input logic [15:0] d);
        vecs[v].ch[i]  = c;
        vecs[v].val[i] = d;
    endtask

    task automatic set_exp(input int v, input int c, input logic emp,
                           input logic [15:0] mn, input logic [15:0] mx);
        vecs[v].eempty[c] = emp;
        vecs[v].emin[c]   = mn;
        vecs[v].emax[c]   = mx;
    endtask

    task automatic push_exp(input int c, input logic emp, input logic [15:0] mn, input logic [15:0] mx);
        exp_t e;
        e.chan  = 2'(c);
        e.empty = emp;
        e.mn    = emp ? 16'h0 : mn;
        e.mx    = emp ? 16'h0 : mx;
        e.rg    = e.mx - e.mn;
        sbq.push_back(e);
    endtask

    task automatic push_vec(input int v);
        for (int c = 0; c < 4; c++)
            push_exp(c, vecs[v].eempty[c], vecs[v].emin[c], vecs[v].emax[c]);
    endtask

    task automatic push_all_empty();
        for (int c = 0; c < 4; c++) push_exp(c, 1'b1, 16'h0, 16'h0);
    endtask

    task automatic send(input logic [1:0] c, input logic [15:0] d, input logic fin);
        data_valid = 1'b1;
        data_chan  = c;
        data_in    = d;
        finish     = fin;
        tick();
        data_valid = 1'b0;
        finish     = 1'b0;
    endtask

    task automatic pulse_go();
        go = 1'b1;
        tick();
        go = 1'b0;
    endtask

    task automatic pulse_finish();
        finish = 1'b1;
        tick();
        finish = 1'b0;
    endtask

    // Pop and compare one expectation per reported channel.
    task automatic collect();
        exp_t e;
        int   waitc;
        waitc = 0;
        @(negedge clock);
        while (!result_valid && waitc < 8) begin
            @(negedge clock);
            waitc++;
        end
        chk("first_result_latency", 32'(waitc), 32'd0);
        if (!result_valid) begin
            sbq.delete();
            return;
        end
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clock);
            chk("result_valid", 32'(result_valid), 32'd1);
            chk("busy_in_report", 32'(busy), 32'd1);
            if (sbq.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL scoreboard_empty: result chan %0d with no expectation", result_chan);
            end else begin
                e = sbq.pop_front();
                chk("result_chan",  32'(result_chan),  32'(e.chan));
                chk("result_min",   32'(result_min),   32'(e.mn));
                chk("result_max",   32'(result_max),   32'(e.mx));
                chk("result_range", 32'(result_range), 32'(e.rg));
                chk("result_empty", 32'(result_empty), 32'(e.empty));
            end
        end
        @(negedge clock);
        chk("valid_after_report", 32'(result_valid), 32'd0);
        chk("busy_after_report",  32'(busy), 32'd0);
        chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
        sbq.delete();
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        reset_n      = 1'b0;
        go           = 1'b0;
        finish       = 1'b0;
        data_valid   = 1'b0;
        data_in      = '0;
        data_chan    = '0;
        go_5         = 1'b0;
        finish_5     = 1'b0;
        data_valid_5 = 1'b0;
        data_in_5    = '0;
        data_chan_5  = '0;

        for (int v = 0; v < 4; v++) vecs[v] = '0;
        // window 1: ch0 10,3,7 and ch2 100; finish in its own cycle
        vecs[0].ns = 3'd4; vecs[0].fin_last = 1'b0;
        add_smp(0, 0, 2'd0, 16'd10); add_smp(0, 1, 2'd0, 16'd3);
        add_smp(0, 2, 2'd0, 16'd7);  add_smp(0, 3, 2'd2, 16'd100);
        set_exp(0, 0, 1'b0, 16'd3, 16'd10);   set_exp(0, 1, 1'b1, 16'd0, 16'd0);
        set_exp(0, 2, 1'b0, 16'd100, 16'd100); set_exp(0, 3, 1'b1, 16'd0, 16'd0);
        // window 2: repeated value on ch1, extremes on ch3, finish with last sample
        vecs[1].ns = 3'd4; vecs[1].fin_last = 1'b1;
        add_smp(1, 0, 2'd1, 16'd5);     add_smp(1, 1, 2'd3, 16'h7FFF);
        add_smp(1, 2, 2'd3, 16'd0);     add_smp(1, 3, 2'd1, 16'd5);
        set_exp(1, 0, 1'b1, 16'd0, 16'd0);   set_exp(1, 1, 1'b0, 16'd5, 16'd5);
        set_exp(1, 2, 1'b1, 16'd0, 16'd0);   set_exp(1, 3, 1'b0, 16'd0, 16'h7FFF);
        // window 3: one sample per channel (including a zero sample)
        vecs[2].ns = 3'd4; vecs[2].fin_last = 1'b0;
        add_smp(2, 0, 2'd0, 16'h1234);  add_smp(2, 1, 2'd1, 16'h0000);
        add_smp(2, 2, 2'd2, 16'h7000);  add_smp(2, 3, 2'd3, 16'h0042);
        set_exp(2, 0, 1'b0, 16'h1234, 16'h1234); set_exp(2, 1, 1'b0, 16'h0, 16'h0);
        set_exp(2, 2, 1'b0, 16'h7000, 16'h7000); set_exp(2, 3, 1'b0, 16'h42, 16'h42);
        // window 4: no samples at all
        vecs[3].ns = 3'd0; vecs[3].fin_last = 1'b0;
        for (int c = 0; c < 4; c++) set_exp(3, c, 1'b1, 16'd0, 16'd0);

        tick(); tick();
        chk("rst_busy",   32'(busy), 32'd0);
        chk("rst_valid",  32'(result_valid), 32'd0);
        chk("rst_error",  32'(debug_error), 32'd0);
        chk("rst_empty",  32'(result_empty), 32'd0);
        chk("rst_chan",   32'(result_chan), 32'd0);
        chk("rst_min",    32'(result_min), 32'd0);
        chk("rst_max",    32'(result_max), 32'd0);
        chk("rst_range",  32'(result_range), 32'd0);
        reset_n = 1'b1;
        tick();

        // Table-driven windows
        for (int v = 0; v < 4; v++) begin
            pulse_go();
            chk("busy_in_run", 32'(busy), 32'd1);
            for (int i = 0; i < int'(vecs[v].ns); i++) begin
                data_valid = 1'b1;
                data_chan  = vecs[v].ch[i];
                data_in    = vecs[v].val[i];
                finish     = vecs[v].fin_last && (i == int'(vecs[v].ns) - 1);
                if (finish) push_vec(v);
                tick();
            end
            data_valid = 1'b0;
            if (!finish) begin
                finish = 1'b1;
                push_vec(v);
                tick();
            end
            finish = 1'b0;
            collect();
            chk("no_error_clean_window", 32'(debug_error), 32'd0);
        end

        // Full-scale sample in the finish cycle
        pulse_go();
        send(2'd1, 16'h0001, 1'b0);
        push_exp(0, 1'b1, 16'h0, 16'h0);
`ifdef RANGE_SIGNED_EN
        push_exp(1, 1'b0, 16'hFFFF, 16'h0001);
`else
        push_exp(1, 1'b0, 16'h0001, 16'hFFFF);
`endif
        push_exp(2, 1'b1, 16'h0, 16'h0);
        push_exp(3, 1'b1, 16'h0, 16'h0);
        send(2'd1, 16'hFFFF, 1'b1);
        collect();

        // go && finish in IDLE: no start, error; clean go clears it
        go = 1'b1; finish = 1'b1;
        tick();
        go = 1'b0; finish = 1'b0;
        chk("gofin_stays_idle", 32'(busy), 32'd0);
        chk("gofin_error", 32'(debug_error), 32'd1);
        pulse_go();
        chk("clean_go_clears_error", 32'(debug_error), 32'd0);
        chk("clean_go_busy", 32'(busy), 32'd1);
        push_all_empty();
        pulse_finish();
        collect();

        // data_valid outside RUN
        send(2'd0, 16'h0009, 1'b0);
        chk("idle_sample_error", 32'(debug_error), 32'd1);
        chk("idle_sample_busy", 32'(busy), 32'd0);

        // go in RUN is ignored (no restart) but flagged
        pulse_go();
        chk("go_clears_error", 32'(debug_error), 32'd0);
        send(2'd0, 16'd50, 1'b0);
        pulse_go();
        chk("go_in_run_error", 32'(debug_error), 32'd1);
        chk("go_in_run_busy", 32'(busy), 32'd1);
        send(2'd0, 16'd60, 1'b0);
        push_exp(0, 1'b0, 16'd50, 16'd60);
        push_exp(1, 1'b1, 16'h0, 16'h0);
        push_exp(2, 1'b1, 16'h0, 16'h0);
        push_exp(3, 1'b1, 16'h0, 16'h0);
        pulse_finish();
        collect();
        chk("error_sticky", 32'(debug_error), 32'd1);

        // Accepted go with a sample in the same cycle: error set beats clear,
        // and the sample is not taken
        go = 1'b1;
        send(2'd0, 16'd5, 1'b0);
        go = 1'b0;
        chk("set_over_clear_error", 32'(debug_error), 32'd1);
        chk("set_over_clear_busy", 32'(busy), 32'd1);
        push_all_empty();
        pulse_finish();
        collect();

        // Signed extremes and a lone negative value
        pulse_go();
        chk("go_clears_error2", 32'(debug_error), 32'd0);
        send(2'd0, 16'h8000, 1'b0);
        send(2'd0, 16'h7FFF, 1'b0);
        send(2'd1, 16'hFFFB, 1'b0);
`ifdef RANGE_SIGNED_EN
        push_exp(0, 1'b0, 16'h8000, 16'h7FFF);
`else
        push_exp(0, 1'b0, 16'h7FFF, 16'h8000);
`endif
        push_exp(1, 1'b0, 16'hFFFB, 16'hFFFB);
        push_exp(2, 1'b1, 16'h0, 16'h0);
        push_exp(3, 1'b1, 16'h0, 16'h0);
        pulse_finish();
        collect();

        // finish in IDLE
        pulse_finish();
        chk("finish_idle_error", 32'(debug_error), 32'd1);
        chk("finish_idle_busy", 32'(busy), 32'd0);

        // Reset during REPORT while channel 1 is on the outputs
        pulse_go();
        send(2'd0, 16'd1, 1'b1);
        @(negedge clock);
        chk("abort_ch0_valid", 32'(result_valid), 32'd1);
        @(negedge clock);
        chk("abort_ch1_chan", 32'(result_chan), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("abort_valid", 32'(result_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_error", 32'(debug_error), 32'd0);
        chk("abort_min", 32'(result_min), 32'd0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        tick();
        chk("after_abort_idle", 32'(busy), 32'd0);
        chk("after_abort_valid", 32'(result_valid), 32'd0);

        // NCH=5 instance: tag 5 is out of range and dropped; tag 4 is valid
        go_5 = 1'b1; tick(); go_5 = 1'b0;
        data_valid_5 = 1'b1; data_chan_5 = 3'd0; data_in_5 = 16'd20; tick();
        data_chan_5 = 3'd5; data_in_5 = 16'd999; tick();
        data_valid_5 = 1'b0;
        chk("bad_chan_error", 32'(debug_error_5), 32'd1);
        chk("bad_chan_busy", 32'(busy_5), 32'd1);
        data_valid_5 = 1'b1; data_chan_5 = 3'd4; data_in_5 = 16'd7; finish_5 = 1'b1;
        tick();
        data_valid_5 = 1'b0; finish_5 = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            chk("n5_valid", 32'(result_valid_5), 32'd1);
            chk("n5_chan", 32'(result_chan_5), 32'(k));
            chk("n5_empty", 32'(result_empty_5), (k == 0 || k == 4) ? 32'd0 : 32'd1);
            chk("n5_min", 32'(result_min_5), (k == 0) ? 32'd20 : (k == 4) ? 32'd7 : 32'd0);
            chk("n5_max", 32'(result_max_5), (k == 0) ? 32'd20 : (k == 4) ? 32'd7 : 32'd0);
        end
        @(negedge clock);
        chk("n5_done_valid", 32'(result_valid_5), 32'd0);
        chk("n5_done_busy", 32'(busy_5), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
